// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state type and constants for the bin2bcd_seq converter
package bin2bcd_pkg;
    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX = 9999;
    localparam int CNT_W = 4;
endpackage

// File: rtl/bin2bcd_seq_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to any digit above 4
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    always_comb q = (d > 4'd4) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD; BIN2BCD_SAT_EN clamps inputs above 9999
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             ready,
    output logic             done_tick,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0,
    output logic             overflow
);
    state_t              state;
    logic [BIN_W-1:0]    shift_reg;
    logic [BIN_W-1:0]    bin_load;
    logic [4*DIGITS-1:0] bcd_work;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_work;
    logic                ovf_load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (.d(bcd_work[4*i +: 4]), .q(bcd_adj[4*i +: 4]));
    end

`ifdef BIN2BCD_SAT_EN
    assign ovf_load = bin > BIN_W'(BCD_MAX);
    assign bin_load = ovf_load ? BIN_W'(BCD_MAX) : bin;
`else
    assign ovf_load = 1'b0;
    assign bin_load = bin;
`endif

    assign ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bcd_work  <= '0;
            cnt       <= '0;
            ovf_work  <= 1'b0;
            done_tick <= 1'b0;
            bcd3      <= '0;
            bcd2      <= '0;
            bcd1      <= '0;
            bcd0      <= '0;
            overflow  <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shift_reg <= bin_load;
                    ovf_work  <= ovf_load;
                    bcd_work  <= '0;
                    cnt       <= CNT_W'(BIN_W);
                    state     <= OP;
                end
                OP: if (cnt == '0) begin
                    state     <= DONE;
                    done_tick <= 1'b1;
                end else begin
                    // top digit's carry-out falls off, giving mod 10000 for large inputs
                    bcd_work  <= {bcd_adj[4*DIGITS-2:0], shift_reg[BIN_W-1]};
                    shift_reg <= shift_reg << 1;
                    cnt       <= cnt - 1'b1;
                end
                DONE: begin
                    {bcd3, bcd2, bcd1, bcd0} <= bcd_work[15:0];
                    overflow <= ovf_work;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq, follows BIN2BCD_SAT_EN like the design
module tb_bin2bcd_seq;
    typedef struct {
        logic [15:0] d;
        logic        o;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        ready, done_tick, overflow;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;
    res_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    bin2bcd_seq dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .ready(ready), .done_tick(done_tick),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] dig();
        return {bcd3, bcd2, bcd1, bcd0};
    endfunction

    function automatic res_t model(input int v);
        res_t r;
        int   x;
`ifdef BIN2BCD_SAT_EN
        r.o = (v > 9999);
        x = r.o ? 9999 : v;
`else
        r.o = 1'b0;
        x = v % 10000;
`endif
        r.d = {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
        return r;
    endfunction

    // called at a falling edge; returns at the falling edge of cycle 0
    task automatic start_conv(input logic [13:0] v);
        bin = v;
        start = 1'b1;
        sb.push_back(model(int'(v)));
        @(negedge clk);
        start = 1'b0;
        bin = 14'($urandom);
    endtask

    task automatic convert(input logic [13:0] v);
        logic [15:0] pd;
        logic        po;
        int          cyc;
        int          lowc;
        res_t        e;
        pd = dig();
        po = overflow;
        start_conv(v);
        cyc = -1;
        lowc = 0;
        for (int k = 0; k < 40 && cyc < 0; k++) begin
            if (!ready) lowc++;
            if (done_tick) cyc = k;
            checks++;
            if (dig() !== pd || overflow !== po) begin
                failures++;
                $display("FAIL hold(bin=%0d,cyc=%0d): got %h/%b want %h/%b", v, k, dig(), overflow, pd, po);
            end
            @(negedge clk);
        end
        checks++;
        if (cyc !== 15) begin
            failures++;
            $display("FAIL latency(bin=%0d): done_tick at cycle %0d want 15", v, cyc);
        end
        checks++;
        if (lowc !== 16) begin
            failures++;
            $display("FAIL ready_low(bin=%0d): got %0d cycles want 16", v, lowc);
        end
        checks++;
        if (ready !== 1'b1 || done_tick !== 1'b0) begin
            failures++;
            $display("FAIL after_done(bin=%0d): ready=%b done_tick=%b want 1/0", v, ready, done_tick);
        end
        e = sb.pop_front();
        checks++;
        if (dig() !== e.d || overflow !== e.o) begin
            failures++;
            $display("FAIL result(bin=%0d): got %h/%b want %h/%b", v, dig(), overflow, e.d, e.o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done_tick !== 1'b0 || dig() !== 16'h0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got r=%b d=%b bcd=%h o=%b want 1/0/0000/0", ready, done_tick, dig(), overflow);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done_tick !== 1'b0 || dig() !== 16'h0) begin
            failures++;
            $display("FAIL reset_release: got r=%b d=%b bcd=%h want 1/0/0000", ready, done_tick, dig());
        end
    endtask

    task automatic test_basic();
        convert(14'd0);
        convert(14'd1000);
        convert(14'd9999);
        convert(14'd1001);
    endtask

    task automatic test_overflow();
        convert(14'd12345);
        convert(14'd16383);
        convert(14'd10000);
        convert(14'd7);
    endtask

    task automatic test_busy_start();
        int   ticks;
        res_t e;
        ticks = 0;
        start_conv(14'd42);
        repeat (5) @(negedge clk);
        start = 1'b1;
        bin = 14'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_tick) ticks++;
            @(negedge clk);
        end
        checks++;
        if (ticks !== 1) begin
            failures++;
            $display("FAIL busy_ticks: got %0d done_tick pulses want 1", ticks);
        end
        e = sb.pop_front();
        checks++;
        if (dig() !== e.d || overflow !== e.o) begin
            failures++;
            $display("FAIL busy_result: got %h/%b want %h/%b", dig(), overflow, e.d, e.o);
        end
    endtask

    task automatic test_reset_mid();
        int   ticks;
        res_t e;
        ticks = 0;
        start_conv(14'd5000);
        e = sb.pop_back();
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (dig() !== 16'h0 || ready !== 1'b1 || done_tick !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: got bcd=%h r=%b d=%b o=%b want 0000/1/0/0", dig(), ready, done_tick, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done_tick) ticks++;
            @(negedge clk);
        end
        checks++;
        if (ticks !== 0 || dig() !== 16'h0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_after: got ticks=%0d bcd=%h r=%b want 0/0000/1", ticks, dig(), ready);
        end
        convert(14'd5000);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) convert(14'($urandom_range(0, 16383)));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
